// File: rtl/core_dispatch_controller.sv
// core_dispatch_controller: starts selected cores on a host launch, gathers done bits, then raises a completion IRQ or a watchdog error.
module core_dispatch_controller #(
  parameter int CORE_NUM  = 4,
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 launch,
  input  logic [CORE_NUM-1:0]  launch_mask,
  input  logic [TIMEOUT_W-1:0] timeout_limit,
  output logic [CORE_NUM-1:0]  core_start,
  input  logic [CORE_NUM-1:0]  core_ack,
  input  logic [CORE_NUM-1:0]  core_done,
  output logic                 busy,
  output logic                 interrupt,
  output logic                 error,
  output logic [CORE_NUM-1:0]  done_status
);
  typedef enum logic [1:0] {IDLE, DISPATCH, RUN, IRQ} state_t;
  state_t               state, state_n;
  logic [CORE_NUM-1:0]  mask, mask_n, start_n, done_n;
  logic [TIMEOUT_W-1:0] count, count_n;
  logic                 error_n, complete, expire;
  always_comb begin
    state_n   = state;
    mask_n    = mask;
    start_n   = core_start;
    done_n    = done_status;
    error_n   = error;
    count_n   = count;
    busy      = state != IDLE;
    interrupt = state == IRQ;
    complete  = (done_status | (core_done & mask)) == mask;
    // expiry is judged against the count value this edge would store
    expire    = timeout_limit != '0 && count + TIMEOUT_W'(1) == timeout_limit;
    case (state)
      IDLE: if (launch && |launch_mask) begin
        state_n = DISPATCH;
        mask_n  = launch_mask;
        start_n = launch_mask;
        done_n  = '0;
        error_n = 1'b0;
        count_n = '0;
      end
      DISPATCH, RUN: begin
        start_n = core_start & ~((core_ack | core_done) & mask);
        done_n  = done_status | (core_done & mask);
        count_n = count + TIMEOUT_W'(1);
        if (complete) state_n = IRQ;
        else if (expire) begin
          state_n = IDLE;
          start_n = '0;
          error_n = 1'b1;
        end else if (start_n == '0) state_n = RUN;
      end
      IRQ: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      mask        <= '0;
      core_start  <= '0;
      done_status <= '0;
      error       <= 1'b0;
      count       <= '0;
    end else begin
      state       <= state_n;
      mask        <= mask_n;
      core_start  <= start_n;
      done_status <= done_n;
      error       <= error_n;
      count       <= count_n;
    end
  end
endmodule

// File: tb/tb_core_dispatch_controller.sv
// tb_core_dispatch_controller: randomized launches against a per-launch outcome model; a monitor scores IRQ/error events.
module tb_core_dispatch_controller;
  logic        clk = 1'b0;
  logic        reset_n, launch;
  logic [3:0]  launch_mask, core_start, core_ack, core_done, done_status;
  logic [15:0] timeout_limit;
  logic        busy, interrupt, error, err_q;
  int          cyc = 0, nvec = 0, nerr = 0;
  int          sa[4], sd[4];
  typedef struct {bit is_err; int cyc; logic [3:0] ds;} exp_t;
  exp_t q[$];
  exp_t e;

  core_dispatch_controller #(.CORE_NUM(4), .TIMEOUT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .launch(launch), .launch_mask(launch_mask),
    .timeout_limit(timeout_limit), .core_start(core_start), .core_ack(core_ack),
    .core_done(core_done), .busy(busy), .interrupt(interrupt), .error(error),
    .done_status(done_status)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", n, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && (interrupt || (error && !err_q))) begin
      if (q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_event at cycle %0d: interrupt=%b error=%b, expected none", cyc, interrupt, error);
      end else begin
        e = q.pop_front();
        chk("event_kind", {30'd0, interrupt, error}, e.is_err ? 1 : 2);
        chk("event_cycle", cyc, e.cyc);
        chk("event_done_status", int'(done_status), int'(e.ds));
      end
    end
    err_q <= error;
  end

  // Outcome of one launch from the per-core ack/done schedule: completion lands on the
  // edge ending cycle C (latest masked done); the watchdog allows lim active cycles.
  task automatic run_launch(input logic [3:0] m, input int lim);
    int c, ke, c1, lastk, mn;
    bit err;
    logic [3:0] ds, st, ack_lvl, done_lvl;
    c = 0;
    for (int i = 0; i < 4; i++) if (m[i] && sd[i] > c) c = sd[i];
    err = lim != 0 && c > lim;
    ke = err ? lim + 1 : c + 1;
    lastk = err ? lim : c;
    ds = '0;
    for (int i = 0; i < 4; i++) ds[i] = m[i] && sd[i] <= lastk;
    ack_lvl = 4'($urandom);
    done_lvl = 4'($urandom);
    @(posedge clk); #1;
    launch = 1'b1; launch_mask = m; timeout_limit = 16'(lim); core_ack = '0; core_done = '0;
    @(posedge clk); #1;
    c1 = cyc;
    q.push_back('{err, c1 + ke - 1, ds});
    for (int k = 1; k <= ke + 1; k++) begin
      for (int i = 0; i < 4; i++) begin
        mn = sa[i] < sd[i] ? sa[i] : sd[i];
        st[i] = m[i] && k <= mn && !(err && k > lim);
      end
      chk("core_start", int'(core_start), int'(st));
      chk("busy", int'(busy), (k < ke || (!err && k == ke)) ? 1 : 0);
      if (k < ke) chk("error_cleared", int'(error), 0);
      if (k == ke + 1) begin
        launch = 1'b0; core_ack = '0; core_done = '0;
      end else begin
        launch = (k < ke || (!err && k == ke)) && $urandom_range(0, 3) == 0;
        launch_mask = 4'($urandom_range(1, 15));
        for (int i = 0; i < 4; i++) begin
          core_ack[i]  = m[i] ? (ack_lvl[i]  ? k >= sa[i] : k == sa[i]) : 1'($urandom % 2);
          core_done[i] = m[i] ? (done_lvl[i] ? k >= sd[i] : k == sd[i]) : 1'($urandom % 2);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic sched(input int a0, a1, a2, a3, d0, d1, d2, d3);
    sa = '{a0, a1, a2, a3};
    sd = '{d0, d1, d2, d3};
  endtask

  initial begin
    reset_n = 1'b0; launch = 1'b0; launch_mask = '0; timeout_limit = '0;
    core_ack = '0; core_done = '0; err_q = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_core_start", int'(core_start), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_interrupt", int'(interrupt), 0);
    chk("reset_error", int'(error), 0);
    chk("reset_done_status", int'(done_status), 0);
    reset_n = 1'b1;
    // core 1 never responds: watchdog of 8 aborts with core 0's partial done
    sched(1, 1000, 1, 1, 3, 1000, 1, 1);
    run_launch(4'b0011, 8);
    chk("error_sticky", int'(error), 1);
    // an all-zero mask is ignored and leaves the error flag alone
    launch = 1'b1; launch_mask = '0;
    @(posedge clk); #1;
    launch = 1'b0;
    chk("mask0_busy", int'(busy), 0);
    chk("mask0_error", int'(error), 1);
    sched(1, 1, 1, 1, 4, 7, 2, 10);
    run_launch(4'b1111, 0);
    sched(2, 9, 3, 9, 6, 1, 5, 2);
    run_launch(4'b0101, 0);
    sched(1000, 1000, 1000, 1000, 1, 1, 1, 1);
    run_launch(4'b0100, 0);
    // completion on the expiry edge wins over the watchdog
    sched(1, 1, 1, 1, 5, 1, 1, 1);
    run_launch(4'b0001, 5);
    sched(1, 1, 1, 1, 1, 1, 1, 1);
    run_launch(4'b1111, 0);
    // reset mid-launch with two starts still pending
    @(posedge clk); #1;
    launch = 1'b1; launch_mask = 4'hF; timeout_limit = '0;
    @(posedge clk); #1;
    launch = 1'b0; core_ack = 4'b0011;
    @(posedge clk); #1;
    core_ack = '0;
    chk("pre_reset_core_start", int'(core_start), 4'b1100);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk("midrun_reset_core_start", int'(core_start), 0);
    chk("midrun_reset_busy", int'(busy), 0);
    chk("midrun_reset_done_status", int'(done_status), 0);
    chk("midrun_reset_interrupt", int'(interrupt), 0);
    for (int n = 0; n < 40; n++) begin
      automatic int lim = ($urandom % 3 == 0) ? 0 : $urandom_range(1, 20);
      for (int i = 0; i < 4; i++) begin
        sd[i] = $urandom_range(1, 15);
        sa[i] = $urandom_range(1, 16);
        if (lim != 0 && $urandom % 5 == 0) begin
          sd[i] = 1000;
          sa[i] = 1000;
        end
      end
      run_launch(4'($urandom_range(1, 15)), lim);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("pending_events", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/core_dispatch_controller.md
Name: core_dispatch_controller

Overview:
Host-to-core launch side of the videocard compute cluster, the counterpart of the completion interrupt path.
- On a host launch, it raises a start request to each selected core and holds it until that core acknowledges.
- It then collects per-core done indications and issues one completion interrupt pulse to the host when every selected core has finished.
- A programmable watchdog aborts hung launches and reports an error.

Parameters:
CORE_NUM, 4, number of shader cores driven; width of all per-core vectors
TIMEOUT_W, 16, width of watchdog counter and timeout_limit

Ports:
clk  input  1  system clock; all state updates on rising edge
reset_n  input  1  synchronous active-low reset
launch  input  1  host launch request, sampled each cycle; acted on only in IDLE
launch_mask  input  CORE_NUM  cores to start; sampled with launch
timeout_limit  input  TIMEOUT_W  watchdog limit in cycles; 0 disables watchdog
core_start  output  CORE_NUM  per-core start request, level, held until ack/done
core_ack  input  CORE_NUM  per-core start acknowledge, level or pulse
core_done  input  CORE_NUM  per-core completion, level or pulse
busy  output  1  high from cycle after accepted launch through IRQ cycle
interrupt  output  1  one-cycle completion pulse to host
error  output  1  sticky watchdog-abort flag, cleared by next accepted launch
done_status  output  CORE_NUM  accumulated done bits of current/last launch

Behaviour:
Reset (reset_n=0 at a rising edge):
- state=IDLE; core_start, done_status, active mask, watchdog count all 0.
- busy=0, interrupt=0, error=0.
- Reset overrides everything, including mid-launch; start requests drop on the next cycle.

State machine (IDLE, DISPATCH, RUN, IRQ):
- IDLE: launch=1 with launch_mask!=0 -> latch mask; core_start<=mask; done_status<=0; error<=0; count<=0; go to DISPATCH.
- IDLE: launch with mask==0 is ignored; no state change, error unchanged.
- DISPATCH: each cycle clear core_start bits where (core_ack|core_done)&mask. OR core_done&mask into done_status.
  - All start bits cleared after this update -> go to RUN.
  - All masked done bits set in the same cycle -> go directly to IRQ.
- RUN: done_status |= core_done&mask; when (updated done_status)==mask -> go to IRQ.
- IRQ: interrupt=1 for exactly this one cycle, busy=1; next cycle go to IDLE.

Rules common to DISPATCH and RUN:
- core_done counts as an implicit ack.
- core_ack/core_done bits outside the mask are ignored.

Latency:
- All cores ack and done in the cycle after the launch edge: interrupt is high on the 2nd cycle after the launch edge.
- Completion in general: interrupt is high the cycle after the edge on which the last done bit is sampled.

Watchdog:
- Active in DISPATCH and RUN only, when timeout_limit!=0.
- count increments each cycle.
- If count==timeout_limit and completion is not reached on that edge:
  - core_start<=0; error<=1; go to IDLE; no interrupt pulse.
  - done_status keeps the partial result.
- Completion on the same edge as expiry wins: go to IRQ, no error.
- Changing timeout_limit mid-launch takes effect immediately.

Other boundary conditions:
- launch while busy is ignored and not queued.
- launch in the IRQ cycle is ignored; a launch on the next cycle (IDLE) is accepted.
- done bits are sticky within a launch; repeated or held done has no further effect.
- Done held high from a previous launch counts immediately in the new launch.

Test Plan:
1. CORE_NUM=4, launch mask=4'b1111, core_ack=4'b1111 one cycle later, core_done bits arriving on different cycles, last one at cycle 10 -> core_start=4'b1111 until the ack edge, busy high, done_status climbs to 4'b1111, one interrupt pulse in cycle 11, then IDLE with busy=0.
2. Mask=4'b0101, core_done pulsed on cores 1 and 3 only, then cores 0 and 2 -> interrupt only after cores 0 and 2 finish; done_status=4'b0101; core_start[1] and core_start[3] never asserted.
3. timeout_limit=8, mask=4'b0011, core 1 never acks -> at the 8th active cycle error=1, core_start=0, no interrupt, busy=0. A following launch clears error.
4. Launch with mask=0 -> no state change, busy=0. A second launch mid-RUN -> ignored, launch completes normally with exactly one interrupt.
5. Core 2 asserts core_done without core_ack (mask=4'b0100) -> start cleared, interrupt pulse on the next cycle.
6. reset_n=0 asserted in RUN with core_start partially set -> next cycle all outputs 0, state IDLE; a new launch afterwards works normally.
